dcache_mem_responder: RTL and testbench
=======================================

// Module: dcache_mem_responder
// PURPOSE
//  Memory-side responder for the data cache. Sits on the far end of the cache's mem_req/mem_rsp ports.
//  Accepts line-sized read/write requests and backs them with a synchronous line-wide SRAM.
//  Returns read data with the original tag after a fixed latency, in request order. Writes are silent.
//  Used as the behavioural main memory in cache subsystem benches and in FPGA bring-up builds.
// PARAMETERS
//  LINE_SIZE       64                    bytes per line; equals DCACHE_LINE_SIZE
//  ADDR_WIDTH      26                    line address width (byte address >> log2(LINE_SIZE))
//  TAG_WIDTH       `DCACHE_MEM_TAG_WIDTH  memory request/response tag width
//  MEM_DEPTH       1024                  lines of backing store; power of 2
//  LATENCY         4                     request-accept to response-valid cycles; >= 1
//  RSP_FIFO_DEPTH  8                     max outstanding reads; >= LATENCY, elaboration error otherwise
// PORTS
//  clk_i            in   1              clock
//  rst_ni           in   1              asynchronous reset, active low
//  mem_req_valid_i  in   1              request valid
//  mem_req_rw_i     in   1              1 = write, 0 = read
//  mem_req_byteen_i in   LINE_SIZE      write byte enables
//  mem_req_addr_i   in   ADDR_WIDTH     line address
//  mem_req_data_i   in   8*LINE_SIZE    write data
//  mem_req_tag_i    in   TAG_WIDTH      request tag
//  mem_req_ready_o  out  1              request ready
//  mem_rsp_valid_o  out  1              read response valid
//  mem_rsp_data_o   out  8*LINE_SIZE    read data
//  mem_rsp_tag_o    out  TAG_WIDTH      tag of the originating read
//  mem_rsp_ready_i  in   1              response ready
// BEHAVIOUR
//  - Handshake on each side is valid & ready at the rising edge. Valid, once raised, is held with stable payload until the handshake.
//  - Index = addr_i[log2(MEM_DEPTH)-1:0]. Upper bits are ignored, so aliasing is allowed.
//  - inflight counter, width clog2(RSP_FIFO_DEPTH+1):
//    - +1 on read accept; -1 on rsp handshake.
//    - Both in the same cycle: unchanged. Never wraps.
//  - mem_req_ready_o = (inflight < RSP_FIFO_DEPTH). Registered-state only; no dependency on valid or rw.
//    - Writes also stall while full, which preserves ordering.
//  - Write accept: each byte b with byteen[b] = 1 is updated; other bytes are kept.
//    - byteen = 0 is a legal no-op.
//    - A read accepted on any later cycle returns the new data.
//  - Read accept at cycle T:
//    - SRAM is read at T.
//    - {data, tag} travel a LATENCY-1 stage valid-tagged pipeline, then are pushed into the response FIFO.
//    - mem_rsp_valid_o rises at T+LATENCY if the FIFO was empty.
//  - Responses leave strictly in accept order. The FIFO cannot overflow because it is credit-bounded by inflight.
//  - mem_rsp_* outputs come from the FIFO head. valid = FIFO non-empty. data/tag hold while valid & !ready.
//  - Throughput is 1 read/cycle sustained when rsp_ready = 1 and RSP_FIFO_DEPTH > LATENCY.
//    - With RSP_FIFO_DEPTH == LATENCY, at most LATENCY reads per LATENCY+1 cycles.
//  - Reset (async assert, sync deassert):
//    - pipeline valids = 0, FIFO empty, inflight = 0.
//    - mem_req_ready_o = 0 while rst_ni = 0; it is 1 on the first cycle after release.
//    - mem_rsp_valid_o = 0, mem_rsp_data_o = 0, mem_rsp_tag_o = 0.
//    - SRAM contents are NOT reset.
//    - Reset mid-operation drops all in-flight reads silently.
// CONFIGURATION
//  DCACHE_MEM_RSP_PERF_EN defined, the block adds:
//    - perf_reads_o   out 32: accepted reads
//    - perf_writes_o  out 32: accepted writes
//    - perf_stalls_o  out 32: cycles with rsp_valid & !rsp_ready
//    - Counters reset to 0, saturate at 2^32-1, never wrap.
//  Not defined: these ports and counters do not exist. Functional behaviour is identical in both cases.
// TESTING
//  1. Reset release, idle -> ready = 1 on cycle 1; rsp_valid stays 0 for 20 cycles.
//  2. Write addr 0x10 data all 0xA5, byteen all 1; read addr 0x10 tag 0x3 at T
//     -> rsp at T+4: data all 0xA5, tag 0x3.
//  3. Write addr 0x10 byteen = 0x1 data byte0 = 0x5A; read back -> byte0 = 0x5A, bytes 1..63 = 0xA5.
//  4. 16 back-to-back reads, tags 0..15, rsp_ready = 1
//     -> 16 responses on consecutive cycles from T+4, tags 0..15 in order.
//  5. rsp_ready = 0, issue reads -> ready drops after 8 accepts. 9th read is held.
//     Raise rsp_ready -> tags return in order, no loss or duplicate.
//  6. Assert rst_ni = 0 with 3 reads in flight -> outputs clear immediately; no stale response after release.

Source files
------------

// File: rtl/dcache_mem_responder.sv
// -----------------------------------------------------------------------------
// dcache_mem_responder
//
// Memory-side responder for the data cache. It accepts line-sized read and
// write requests and backs them with a line-wide synchronous SRAM. Each read
// returns its data and original tag exactly LATENCY cycles after acceptance
// when the response path is idle, strictly in acceptance order. Writes do not
// produce a response.
//
// Optional feature macro: DCACHE_MEM_RSP_PERF_EN adds three saturating
// 32-bit performance counters (perf_reads_o, perf_writes_o, perf_stalls_o).
//
// Ports
//   clk_i             clock
//   rst_ni            asynchronous reset, active low
//   mem_req_valid_i   request valid
//   mem_req_rw_i      1 = write, 0 = read
//   mem_req_byteen_i  write byte enables (one per byte of the line)
//   mem_req_addr_i    line address; only the low log2(MEM_DEPTH) bits index
//   mem_req_data_i    write data
//   mem_req_tag_i     request tag
//   mem_req_ready_o   request ready
//   mem_rsp_valid_o   read response valid
//   mem_rsp_data_o    read data (0 while no response is pending)
//   mem_rsp_tag_o     tag of the originating read (0 while idle)
//   mem_rsp_ready_i   response ready
//   perf_*_o          (DCACHE_MEM_RSP_PERF_EN only) accepted reads, accepted
//                     writes, cycles with a stalled response
//
// Handshake: on both the request and the response side a transfer happens on
// the rising clock edge where valid and ready are both 1. A source that raises
// valid keeps it high with a stable payload until that edge; ready never
// depends combinationally on valid.
// -----------------------------------------------------------------------------
`ifndef DCACHE_MEM_TAG_WIDTH
`define DCACHE_MEM_TAG_WIDTH 8
`endif

module dcache_mem_responder #(
  parameter int LINE_SIZE      = 64,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = `DCACHE_MEM_TAG_WIDTH,
  parameter int MEM_DEPTH      = 1024,
  parameter int LATENCY        = 4,
  parameter int RSP_FIFO_DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mem_req_valid_i,
  input  logic                   mem_req_rw_i,
  input  logic [LINE_SIZE-1:0]   mem_req_byteen_i,
  input  logic [ADDR_WIDTH-1:0]  mem_req_addr_i,
  input  logic [8*LINE_SIZE-1:0] mem_req_data_i,
  input  logic [TAG_WIDTH-1:0]   mem_req_tag_i,
  output logic                   mem_req_ready_o,
  output logic                   mem_rsp_valid_o,
  output logic [8*LINE_SIZE-1:0] mem_rsp_data_o,
  output logic [TAG_WIDTH-1:0]   mem_rsp_tag_o,
  input  logic                   mem_rsp_ready_i
`ifdef DCACHE_MEM_RSP_PERF_EN
  ,
  output logic [31:0]            perf_reads_o,
  output logic [31:0]            perf_writes_o,
  output logic [31:0]            perf_stalls_o
`endif
);

  localparam int DW   = 8 * LINE_SIZE;
  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam int IW   = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int PW   = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
  localparam logic [IW-1:0] FULL_CNT = IW'(RSP_FIFO_DEPTH);

  if (LATENCY < 1) begin : g_bad_latency
    $error("dcache_mem_responder: LATENCY must be >= 1");
  end
  if (RSP_FIFO_DEPTH < LATENCY) begin : g_bad_depth
    $error("dcache_mem_responder: RSP_FIFO_DEPTH must be >= LATENCY");
  end

  // Upper address bits alias onto the same line by design.
  if (ADDR_WIDTH > IDXW) begin : g_addr_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_req_addr_i[ADDR_WIDTH-1:IDXW];
  end

  logic            ready_q;
  logic            fifo_valid;
  logic            rd_fire, wr_fire, rsp_fire;
  logic [IDXW-1:0] idx;

  assign idx      = mem_req_addr_i[IDXW-1:0];
  assign rd_fire  = mem_req_valid_i & ready_q & ~mem_req_rw_i;
  assign wr_fire  = mem_req_valid_i & ready_q & mem_req_rw_i;
  assign rsp_fire = fifo_valid & mem_rsp_ready_i;

  // ---------------------------------------------------------------- SRAM
  logic [DW-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int b = 0; b < LINE_SIZE; b++) begin
        if (mem_req_byteen_i[b]) mem_q[idx][8*b +: 8] <= mem_req_data_i[8*b +: 8];
      end
    end
  end

  // ------------------------------------------------------ read pipeline
  // LATENCY-1 register stages; the FIFO write adds the final cycle.
  logic                 push_v;
  logic [DW-1:0]        push_d;
  logic [TAG_WIDTH-1:0] push_t;

  if (LATENCY == 1) begin : g_no_pipe
    assign push_v = rd_fire;
    assign push_d = mem_q[idx];
    assign push_t = mem_req_tag_i;
  end else begin : g_pipe
    localparam int NS = LATENCY - 1;
    logic                 pv [NS];
    logic [DW-1:0]        pd [NS];
    logic [TAG_WIDTH-1:0] pt [NS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < NS; i++) pv[i] <= 1'b0;
      end else begin
        pv[0] <= rd_fire;
        for (int i = 1; i < NS; i++) pv[i] <= pv[i-1];
      end
    end

    // Payload registers only load behind a valid bit, so they need no reset.
    always_ff @(posedge clk_i) begin
      if (rd_fire) begin
        pd[0] <= mem_q[idx];
        pt[0] <= mem_req_tag_i;
      end
      for (int i = 1; i < NS; i++) begin
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
          pt[i] <= pt[i-1];
        end
      end
    end

    assign push_v = pv[NS-1];
    assign push_d = pd[NS-1];
    assign push_t = pt[NS-1];
  end

  // ------------------------------------------------------ response FIFO
  // Never overflows: inflight counts pipeline plus FIFO occupancy and new
  // reads are refused once it reaches RSP_FIFO_DEPTH.
  logic [DW-1:0]        fifo_d [RSP_FIFO_DEPTH];
  logic [TAG_WIDTH-1:0] fifo_t [RSP_FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [IW-1:0]        fifo_cnt_q;
  logic [IW-1:0]        inflight_q, inflight_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_valid = (fifo_cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (push_v) begin
      fifo_d[wr_ptr_q] <= push_d;
      fifo_t[wr_ptr_q] <= push_t;
    end
  end

  always_comb begin
    inflight_nxt = inflight_q;
    if (rd_fire && !rsp_fire)      inflight_nxt = inflight_q + IW'(1);
    else if (!rd_fire && rsp_fire) inflight_nxt = inflight_q - IW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      if (push_v)   wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rsp_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_v, rsp_fire})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + IW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - IW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      inflight_q <= inflight_nxt;
      // Registered copy of (inflight < depth): low through reset, high on the
      // first edge after release.
      ready_q    <= (inflight_nxt < FULL_CNT);
    end
  end

  assign mem_req_ready_o = ready_q;
  assign mem_rsp_valid_o = fifo_valid;
  assign mem_rsp_data_o  = fifo_valid ? fifo_d[rd_ptr_q] : '0;
  assign mem_rsp_tag_o   = fifo_valid ? fifo_t[rd_ptr_q] : '0;

`ifdef DCACHE_MEM_RSP_PERF_EN
  logic [31:0] perf_reads_q, perf_writes_q, perf_stalls_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (rd_fire && perf_reads_q != '1)  perf_reads_q  <= perf_reads_q + 32'd1;
      if (wr_fire && perf_writes_q != '1) perf_writes_q <= perf_writes_q + 32'd1;
      if (fifo_valid && !mem_rsp_ready_i && perf_stalls_q != '1)
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_reads_o  = perf_reads_q;
  assign perf_writes_o = perf_writes_q;
  assign perf_stalls_o = perf_stalls_q;
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_dcache_mem_responder
//
// Self-checking bench for dcache_mem_responder. Inputs change on the falling
// clock edge; the response monitor samples 2 ns after the falling edge. A line
// memory model and an ordered expected-response queue predict every response.
// Cycle numbers are the value of cyc observed during a cycle; a read presented
// in cycle A must have its response valid no earlier than cycle A+LAT.
// -----------------------------------------------------------------------------
module tb_dcache_mem_responder;

  localparam int TW  = 8;
  localparam int DW  = 512;
  localparam int LAT = 4;
  localparam int W   = TW + DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_rw;
  logic [63:0]     req_byteen;
  logic [25:0]     req_addr;
  logic [DW-1:0]   req_data;
  logic [TW-1:0]   req_tag;
  logic            req_ready;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [TW-1:0]   rsp_tag;
  logic            rsp_ready;
`ifdef DCACHE_MEM_RSP_PERF_EN
  logic [31:0]     perf_reads, perf_writes, perf_stalls;
`endif

  dcache_mem_responder #(.TAG_WIDTH(TW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .mem_req_valid_i  (req_valid),
    .mem_req_rw_i     (req_rw),
    .mem_req_byteen_i (req_byteen),
    .mem_req_addr_i   (req_addr),
    .mem_req_data_i   (req_data),
    .mem_req_tag_i    (req_tag),
    .mem_req_ready_o  (req_ready),
    .mem_rsp_valid_o  (rsp_valid),
    .mem_rsp_data_o   (rsp_data),
    .mem_rsp_tag_o    (rsp_tag),
    .mem_rsp_ready_i  (rsp_ready)
`ifdef DCACHE_MEM_RSP_PERF_EN
    ,
    .perf_reads_o     (perf_reads),
    .perf_writes_o    (perf_writes),
    .perf_stalls_o    (perf_stalls)
`endif
  );

  // ------------------------------------------------- clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ model / scoreboard
  logic [DW-1:0] model_mem [1024];
  logic [W-1:0]  exp_q[$];
  int            acc_q[$];
  int            got_cyc_q[$];
  logic [TW-1:0] got_tag_q[$];
  logic [DW-1:0] got_data_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            rand_done;

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic void model_write(input int idx, input logic [DW-1:0] d,
                                      input logic [63:0] be);
    for (int b = 0; b < 64; b++)
      if (be[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic void clear_got();
    got_cyc_q.delete();
    got_tag_q.delete();
    got_data_q.delete();
  endfunction

  // Response monitor: every handshake is compared with the oldest expectation.
  logic [W-1:0] mon_exp;
  int           mon_acc;
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_spurious: got tag %0h in cycle %0d, required no response", rsp_tag, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_acc = acc_q.pop_front();
        if ({rsp_tag, rsp_data} !== mon_exp) begin
          errors++;
          $display("FAIL rsp_payload: got tag %0h data %h, required tag %0h data %h",
                   rsp_tag, rsp_data, mon_exp[W-1:DW], mon_exp[DW-1:0]);
        end
        checks++;
        if (cyc < mon_acc + LAT) begin
          errors++;
          $display("FAIL rsp_early: response in cycle %0d, required >= %0d", cyc, mon_acc + LAT);
        end
      end
      got_cyc_q.push_back(cyc);
      got_tag_q.push_back(rsp_tag);
      got_data_q.push_back(rsp_data);
    end
  end

  // ------------------------------------------------------------ drivers
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic rw, input logic [25:0] addr, input logic [DW-1:0] data,
                       input logic [63:0] be, input logic [TW-1:0] tag, output int acc);
    int n = 0;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_data = data;
    req_byteen = be; req_tag = tag;
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    acc = cyc;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept_timeout: ready=%b after %0d cycles, required 1", req_ready, n);
    end else if (rw) begin
      model_write(int'(addr % 1024), data, be);
    end else begin
      exp_q.push_back({tag, model_mem[int'(addr % 1024)]});
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got_tag_q.size() < n && k < 200) begin @(negedge clk); #3; k++; end
    @(negedge clk);
    checks++;
    if (got_tag_q.size() < n) begin
      errors++;
      $display("FAIL rsp_wait_timeout: got %0d responses, required %0d", got_tag_q.size(), n);
    end
  endtask

  task automatic prefill(input int n);
    int a;
    for (int i = 0; i < n; i++)
      issue(1'b1, {16'($urandom), 10'(i)}, rand_line(), '1, '0, a);
  endtask

  // -------------------------------------------------------------- tests
  task automatic test_reset();
    bit seen = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_byteen = '0; req_addr = '0;
    req_data = '0; req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h, required 0", rsp_data); end
    checks++; if (rsp_tag !== '0) begin errors++; $display("FAIL reset_rsp_tag: got %h, required 0", rsp_tag); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready: got %b, required 1", req_ready); end
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 1'b0) seen = 1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL idle_rsp_valid: got 1 while idle, required 0"); end
  endtask

  task automatic test_write_read();
    int a, w;
    clear_got();
    issue(1'b1, 26'h10, {64{8'hA5}}, '1, 8'h0, w);
    issue(1'b0, 26'h10, '0, '0, 8'h3, a);
    wait_got(1);
    if (got_tag_q.size() >= 1) begin
      checks++; if (got_tag_q[0] !== 8'h3) begin errors++; $display("FAIL wr_rd_tag: got %h, required 03", got_tag_q[0]); end
      checks++; if (got_data_q[0] !== {64{8'hA5}}) begin errors++; $display("FAIL wr_rd_data: got %h, required all a5", got_data_q[0]); end
      checks++; if (got_cyc_q[0] != a + LAT) begin errors++; $display("FAIL wr_rd_latency: got cycle %0d, required %0d", got_cyc_q[0], a + LAT); end
    end
  endtask

  task automatic test_byte_enable();
    int a;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    e = {{63{8'hA5}}, 8'h5A};
    d = rand_line(); d[7:0] = 8'h5A;
    clear_got();
    issue(1'b1, 26'h10, d, 64'h1, 8'h0, a);
    issue(1'b0, 26'h10, '0, '0, 8'h4, a);
    issue(1'b1, {16'h1234, 10'h10}, rand_line(), '0, 8'h0, a);   // no-op write, aliased
    issue(1'b0, 26'h10, '0, '0, 8'h5, a);
    issue(1'b1, 26'h10, rand_line(), {$urandom, $urandom}, 8'h0, a);
    issue(1'b0, {16'hBEEF, 10'h10}, '0, '0, 8'h6, a);
    wait_got(3);
    if (got_data_q.size() >= 2) begin
      checks++; if (got_data_q[0] !== e) begin errors++; $display("FAIL byteen_partial: got %h, required %h", got_data_q[0], e); end
      checks++; if (got_data_q[1] !== e) begin errors++; $display("FAIL byteen_zero: got %h, required %h", got_data_q[1], e); end
    end
  endtask

  task automatic test_back_to_back();
    int acc [16];
    prefill(16);
    clear_got();
    for (int i = 0; i < 16; i++)
      issue(1'b0, {16'($urandom), 10'(i)}, '0, '0, TW'(i), acc[i]);
    wait_got(16);
    if (got_tag_q.size() >= 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (acc[i] != acc[0] + i) begin errors++; $display("FAIL b2b_accept[%0d]: cycle %0d, required %0d", i, acc[i], acc[0] + i); end
        checks++;
        if (got_tag_q[i] !== TW'(i)) begin errors++; $display("FAIL b2b_tag[%0d]: got %h, required %h", i, got_tag_q[i], TW'(i)); end
        checks++;
        if (got_cyc_q[i] != acc[0] + LAT + i) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d, required %0d", i, got_cyc_q[i], acc[0] + LAT + i); end
      end
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int i = 0;
    int a;
    rsp_ready = 1'b0;
    clear_got();
    req_valid = 1'b1; req_rw = 1'b0; req_byteen = '0; req_data = '0;
    req_addr = 26'(i); req_tag = TW'(8'h20 + i);
    for (int c = 0; c < 20; c++) begin
      if (req_ready === 1'b1) begin
        exp_q.push_back({req_tag, model_mem[i]});
        acc_q.push_back(cyc);
        n_acc++;
        @(negedge clk);
        i++;
        req_addr = 26'(i); req_tag = TW'(8'h20 + i);
      end else begin
        @(negedge clk);
      end
    end
    checks++; if (n_acc != 8) begin errors++; $display("FAIL bp_accepts: got %0d, required 8", n_acc); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b, required 0", req_ready); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b, required 1", rsp_valid); end
    checks++; if (rsp_tag !== 8'h20) begin errors++; $display("FAIL bp_head_tag: got %h, required 20", rsp_tag); end
    checks++; if (rsp_data !== model_mem[0]) begin errors++; $display("FAIL bp_head_data: got %h, required %h", rsp_data, model_mem[0]); end
    checks++; if (got_tag_q.size() != 0) begin errors++; $display("FAIL bp_no_rsp: got %0d responses, required 0", got_tag_q.size()); end
    rsp_ready = 1'b1;
    for (int k = 8; k < 12; k++) issue(1'b0, 26'(k), '0, '0, TW'(8'h20 + k), a);
    wait_got(12);
    for (int k = 0; k < 12 && k < got_tag_q.size(); k++) begin
      checks++;
      if (got_tag_q[k] !== TW'(8'h20 + k)) begin errors++; $display("FAIL bp_order[%0d]: got %h, required %h", k, got_tag_q[k], TW'(8'h20 + k)); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_lost: %0d responses missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    int a;
    bit seen = 0;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) issue(1'b0, 26'(k), '0, '0, TW'(8'h40 + k), a);
    repeat (5) @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b, required 1", rsp_valid); end
    exp_q.delete(); acc_q.delete();
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL mid_rsp_data: got %h, required 0", rsp_data); end
    checks++; if (rsp_tag !== '0) begin errors++; $display("FAIL mid_rsp_tag: got %h, required 0", rsp_tag); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_req_ready: got %b, required 0", req_ready); end
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b, required 1", req_ready); end
    for (int k = 0; k < 15; k++) begin
      if (rsp_valid !== 1'b0) seen = 1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_stale_rsp: got valid after release, required 0"); end
    clear_got();
    issue(1'b0, 26'd5, '0, '0, 8'h55, a);
    wait_got(1);
    if (got_tag_q.size() >= 1) begin
      checks++; if (got_tag_q[0] !== 8'h55) begin errors++; $display("FAIL mid_fresh_tag: got %h, required 55", got_tag_q[0]); end
    end
  endtask

  task automatic test_random();
    int k = 0;
    prefill(32);
    rand_done = 0;
    fork
      begin
        int a;
        logic [63:0] be;
        for (int n = 0; n < 300; n++) begin
          case ($urandom_range(0, 3))
            0: be = '0;
            1: be = '1;
            default: be = {$urandom, $urandom};
          endcase
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          else issue($urandom_range(0, 2) == 0, {16'($urandom), 10'($urandom_range(0, 31))},
                     rand_line(), be, TW'($urandom), a);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && k < 200) begin @(negedge clk); #3; k++; end
    @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: %0d responses outstanding, required 0", exp_q.size()); end
  endtask

  // ------------------------------------------------------------- report
  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
